// File: rtl/counter_updown_param_if.sv
// ---------------------------------------------------------------------------
// counter_updown_param_if
// Control/status bundle for the parametrised up/down counter.
//   master : drives en, mode, sat, clr, ld, d_in, step; observes status
//   slave  : the counter itself; observes controls, drives count and flags
// Signals:
//   en, mode, sat, clr, ld  - 1-bit controls (enable, up/down, saturate,
//                             synchronous clear, synchronous load)
//   d_in [WIDTH]            - load value
//   step [STEP_W]           - increment/decrement magnitude
//   count [WIDTH]           - registered count
//   at_max, at_min          - count sits on the upper/lower bound
//   ovf, unf                - one-cycle crossing pulses
//   ovf_sticky, unf_sticky  - latched crossing history
// ---------------------------------------------------------------------------
interface counter_updown_param_if #(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 4
);
  logic              en;
  logic              mode;
  logic              sat;
  logic              clr;
  logic              ld;
  logic [WIDTH-1:0]  d_in;
  logic [STEP_W-1:0] step;
  logic [WIDTH-1:0]  count;
  logic              at_max;
  logic              at_min;
  logic              ovf;
  logic              unf;
  logic              ovf_sticky;
  logic              unf_sticky;

  modport master (
    output en, mode, sat, clr, ld, d_in, step,
    input  count, at_max, at_min, ovf, unf, ovf_sticky, unf_sticky
  );

  modport slave (
    input  en, mode, sat, clr, ld, d_in, step,
    output count, at_max, at_min, ovf, unf, ovf_sticky, unf_sticky
  );
endinterface

// File: rtl/counter_updown_param.sv
// ---------------------------------------------------------------------------
// counter_updown_param
// Parametrised up/down counter with programmable inclusive bounds
// [MIN_VAL, MAX_VAL], variable step, wrap-to-opposite-bound or saturate
// behaviour, boundary decode and overflow/underflow pulse + sticky flags.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset (count = RST_VAL, flags cleared)
//   bus  - counter_updown_param_if.slave (controls in, count/flags out)
// Per-edge priority: ld > clr > en; otherwise the count holds.
// ---------------------------------------------------------------------------
module counter_updown_param #(
  parameter int          WIDTH   = 8,
  parameter int          STEP_W  = 4,
  parameter int unsigned MIN_VAL = 0,
  parameter int unsigned MAX_VAL = 255,
  parameter int unsigned RST_VAL = 0
) (
  input logic                   clk,
  input logic                   rst,
  counter_updown_param_if.slave bus
);

  // Arithmetic width: one guard bit above the wider of count and step, so
  // neither the sum nor the lower-bound test can wrap modulo 2^WIDTH.
  localparam int AW = ((STEP_W > WIDTH) ? STEP_W : WIDTH) + 1;

  localparam logic [AW-1:0]    MIN_X = AW'(MIN_VAL);
  localparam logic [AW-1:0]    MAX_X = AW'(MAX_VAL);
  localparam logic [WIDTH-1:0] MIN_W = WIDTH'(MIN_VAL);
  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] RST_W = WIDTH'(RST_VAL);

  logic [WIDTH-1:0] count_p0;
  logic             ovf_p0;
  logic             unf_p0;
  logic             ovs_p0;
  logic             uns_p0;

  logic [AW-1:0]    cnt_x;
  logic [AW-1:0]    step_x;
  logic [AW-1:0]    sum_x;
  logic [AW-1:0]    diff_x;
  logic [AW-1:0]    dn_lim_x;

  logic [WIDTH-1:0] nxt_cnt;
  logic             nxt_ovf;
  logic             nxt_unf;
  logic             nxt_ovs;
  logic             nxt_uns;

  // Load values outside the window are pulled onto the nearest bound.
  function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
    logic [AW-1:0] vx;
    vx = AW'(v);
    if (vx > MAX_X)      return MAX_W;
    else if (vx < MIN_X) return MIN_W;
    else                 return v;
  endfunction

  // Landing value after a bound crossing: saturate stays on the crossed
  // bound, wrap jumps to the opposite one (never a modular remainder).
  function automatic logic [WIDTH-1:0] cross_sel(input logic sat_i,
                                                 input logic up_i);
    if (sat_i) return up_i ? MAX_W : MIN_W;
    else       return up_i ? MIN_W : MAX_W;
  endfunction

  assign cnt_x    = AW'(count_p0);
  assign step_x   = AW'(bus.step);
  assign sum_x    = cnt_x + step_x;
  assign diff_x   = cnt_x - step_x;
  assign dn_lim_x = MIN_X + step_x;

  always_comb begin
    nxt_cnt = count_p0;
    nxt_ovf = 1'b0;
    nxt_unf = 1'b0;
    nxt_ovs = ovs_p0;
    nxt_uns = uns_p0;
    if (bus.ld) begin
      nxt_cnt = clamp_load(bus.d_in);
    end else if (bus.clr) begin
      nxt_cnt = RST_W;
      nxt_ovs = 1'b0;
      nxt_uns = 1'b0;
    end else if (bus.en) begin
      if (bus.mode) begin
        // Holding at MAX with sat=1 still reports the overflow attempt.
        if (sum_x <= MAX_X) begin
          nxt_cnt = WIDTH'(sum_x);
        end else begin
          nxt_ovf = 1'b1;
          nxt_cnt = cross_sel(bus.sat, 1'b1);
        end
      end else begin
        // Compare against MIN+step rather than testing count-step, which
        // could wrap below zero.
        if (cnt_x >= dn_lim_x) begin
          nxt_cnt = WIDTH'(diff_x);
        end else begin
          nxt_unf = 1'b1;
          nxt_cnt = cross_sel(bus.sat, 1'b0);
        end
      end
      nxt_ovs = ovs_p0 | nxt_ovf;
      nxt_uns = uns_p0 | nxt_unf;
    end
  end

  // ---- stage p0: count and flag registers ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_p0 <= RST_W;
      ovf_p0   <= 1'b0;
      unf_p0   <= 1'b0;
      ovs_p0   <= 1'b0;
      uns_p0   <= 1'b0;
    end else begin
      count_p0 <= nxt_cnt;
      ovf_p0   <= nxt_ovf;
      unf_p0   <= nxt_unf;
      ovs_p0   <= nxt_ovs;
      uns_p0   <= nxt_uns;
    end
  end

  // ---- outputs: bound decode straight off the count register ----
  assign bus.count      = count_p0;
  assign bus.at_max     = (count_p0 == MAX_W);
  assign bus.at_min     = (count_p0 == MIN_W);
  assign bus.ovf        = ovf_p0;
  assign bus.unf        = unf_p0;
  assign bus.ovf_sticky = ovs_p0;
  assign bus.unf_sticky = uns_p0;

endmodule

// File: tb/tb_counter_updown_param.sv
// ---------------------------------------------------------------------------
// tb_counter_updown_param
// Directed scenarios for the bounded counter (MIN=10, MAX=20, RST=12)
// followed by randomized control traffic, all compared every cycle against
// an integer reference model of the counting rules.
// ---------------------------------------------------------------------------
module tb_counter_updown_param;

  localparam int WIDTH  = 8;
  localparam int STEP_W = 4;
  localparam int MINV   = 10;
  localparam int MAXV   = 20;
  localparam int RSTV   = 12;

  logic clk;
  logic rst;

  counter_updown_param_if #(.WIDTH(WIDTH), .STEP_W(STEP_W)) bus ();

  counter_updown_param #(
    .WIDTH  (WIDTH),
    .STEP_W (STEP_W),
    .MIN_VAL(MINV),
    .MAX_VAL(MAXV),
    .RST_VAL(RSTV)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  int m_cnt;
  int m_ovf;
  int m_unf;
  int m_ovs;
  int m_uns;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt = RSTV; m_ovf = 0; m_unf = 0; m_ovs = 0; m_uns = 0;
  endtask

  // One clock edge of the counting rules, in plain integer arithmetic.
  task automatic model_edge();
    int s;
    m_ovf = 0;
    m_unf = 0;
    if (bus.ld) begin
      s = int'(bus.d_in);
      m_cnt = (s > MAXV) ? MAXV : ((s < MINV) ? MINV : s);
    end else if (bus.clr) begin
      m_cnt = RSTV; m_ovs = 0; m_uns = 0;
    end else if (bus.en) begin
      if (bus.mode) begin
        s = m_cnt + int'(bus.step);
        if (s > MAXV) begin
          m_ovf = 1;
          m_cnt = bus.sat ? MAXV : MINV;
        end else m_cnt = s;
      end else begin
        s = m_cnt - int'(bus.step);
        if (s < MINV) begin
          m_unf = 1;
          m_cnt = bus.sat ? MINV : MAXV;
        end else m_cnt = s;
      end
      if (m_ovf != 0) m_ovs = 1;
      if (m_unf != 0) m_uns = 1;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".count"},  32'(bus.count),      32'(m_cnt));
    chk({tag, ".at_max"}, 32'(bus.at_max),     32'(m_cnt == MAXV));
    chk({tag, ".at_min"}, 32'(bus.at_min),     32'(m_cnt == MINV));
    chk({tag, ".ovf"},    32'(bus.ovf),        32'(m_ovf));
    chk({tag, ".unf"},    32'(bus.unf),        32'(m_unf));
    chk({tag, ".ovs"},    32'(bus.ovf_sticky), 32'(m_ovs));
    chk({tag, ".uns"},    32'(bus.unf_sticky), 32'(m_uns));
  endtask

  // Called with clk low; returns at the following negedge.
  task automatic cyc(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
    @(negedge clk);
  endtask

  task automatic drive(input logic ld, input logic clr, input logic en,
                       input logic mode, input logic sat,
                       input logic [STEP_W-1:0] step,
                       input logic [WIDTH-1:0] d);
    bus.ld = ld; bus.clr = clr; bus.en = en; bus.mode = mode;
    bus.sat = sat; bus.step = step; bus.d_in = d;
  endtask

  // Reset asserted between edges; effect must be visible before any edge.
  task automatic async_reset(input string tag);
    #1 rst = 1'b1;
    #1;
    model_reset();
    check_all(tag);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    model_reset();
    repeat (2) @(negedge clk);
    check_all("reset");
    rst = 1'b0;

    // 1: async reset mid-count, then count up from RST_VAL
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 8'd17); cyc("s1_ld17");
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd1, 8'd0);
    async_reset("s1_rst");
    chk("s1_rst_lit", 32'(bus.count), 32'd12);
    cyc("s1_up13"); chk("s1_lit13", 32'(bus.count), 32'd13);
    cyc("s1_up14");
    cyc("s1_up15"); chk("s1_lit15", 32'(bus.count), 32'd15);

    // 2: overflow with wrap, then saturate and hold at MAX
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd3, 8'd18); cyc("s2_ld");
    bus.ld = 1'b0; bus.en = 1'b1;
    cyc("s2_wrap"); chk("s2_wrap_lit", 32'(bus.count), 32'd10);
    chk("s2_ovf_lit", 32'(bus.ovf), 32'd1);
    cyc("s2_after");
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'd3, 8'd18); cyc("s2_ld2");
    bus.ld = 1'b0; bus.en = 1'b1;
    cyc("s2_sat");  chk("s2_sat_lit", 32'(bus.count), 32'd20);
    cyc("s2_hold"); chk("s2_hold_ovf", 32'(bus.ovf), 32'd1);

    // 3: underflow with wrap, then saturate at MIN
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2, 8'd11); cyc("s3_ld");
    bus.ld = 1'b0; bus.en = 1'b1;
    cyc("s3_wrap"); chk("s3_wrap_lit", 32'(bus.count), 32'd20);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 8'd11); cyc("s3_ld2");
    bus.ld = 1'b0; bus.en = 1'b1;
    cyc("s3_sat"); chk("s3_sat_lit", 32'(bus.count), 32'd10);

    // 4: load priority and clamping; stickies untouched
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'd1, 8'd15); cyc("s4_ld15");
    chk("s4_ld15_lit", 32'(bus.count), 32'd15);
    bus.d_in = 8'd250; cyc("s4_ld250");
    chk("s4_ld250_lit", 32'(bus.count), 32'd20);
    bus.d_in = 8'd3;   cyc("s4_ld3");
    chk("s4_ld3_lit", 32'(bus.count), 32'd10);

    // 5: clear beats an enabled count that would overflow
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd15, 8'd0); cyc("s5_clr");
    chk("s5_ovs_lit", 32'(bus.ovf_sticky), 32'd0);

    // 6: zero step and disabled count both hold
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 8'd0); cyc("s6_step0");
    bus.mode = 1'b0; cyc("s6_step0_dn");
    bus.en = 1'b0; bus.step = 4'd5; cyc("s6_en0");

    // Randomized traffic with occasional async resets
    for (int i = 0; i < 400; i++) begin
      bus.ld   = ($urandom_range(0, 15) == 0);
      bus.clr  = ($urandom_range(0, 15) == 0);
      bus.en   = ($urandom_range(0, 3) != 0);
      bus.mode = 1'($urandom);
      bus.sat  = 1'($urandom);
      bus.step = STEP_W'($urandom);
      bus.d_in = WIDTH'($urandom);
      if ($urandom_range(0, 49) == 0) async_reset("rnd_rst");
      cyc("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Hard stop in case the stimulus process ever stalls.
  initial begin
    #200000;
    $display("FAIL timeout: got %0d vectors expected completion", n_vec);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/counter_updown_param.md
Name: counter_updown_param

Overview:
- Parametrised synchronous up/down counter; next generation of the team's 8-bit up/down counter.
- Adds configurable width, programmable bounds, variable step, enable, wrap/saturate mode, and boundary flags.
- Used as a general-purpose event/address counter in datapath and control blocks.

Parameters:
WIDTH, 8, counter width in bits (2..32)
STEP_W, 4, width of step input
MIN_VAL, 0, lower count bound, inclusive
MAX_VAL, 255, upper count bound, inclusive; MIN_VAL < MAX_VAL <= 2^WIDTH-1
RST_VAL, 0, value loaded by rst and clr; must lie in [MIN_VAL, MAX_VAL]

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
en  input  1  count enable
mode  input  1  1 = count up, 0 = count down
sat  input  1  1 = saturate at bound, 0 = wrap to opposite bound
clr  input  1  synchronous clear to RST_VAL
ld  input  1  synchronous load of d_in
d_in  input  WIDTH  load value
step  input  STEP_W  increment/decrement magnitude
count  output  WIDTH  registered count value
at_max  output  1  count == MAX_VAL (decoded from count register)
at_min  output  1  count == MIN_VAL (decoded from count register)
ovf  output  1  one-cycle registered pulse: up-count crossed MAX_VAL
unf  output  1  one-cycle registered pulse: down-count crossed MIN_VAL
ovf_sticky  output  1  set by any ovf event, cleared only by rst or clr
unf_sticky  output  1  set by any unf event, cleared only by rst or clr

Behaviour:
- Reset: rst high asynchronously forces count=RST_VAL and ovf=unf=ovf_sticky=unf_sticky=0. Reset wins over all other inputs, including mid-operation.
- Priority per clk edge when rst low: ld > clr > en. No operation when none are asserted; count holds.
- ld: count <= d_in clamped into range. Values above MAX_VAL load MAX_VAL; values below MIN_VAL load MIN_VAL. ovf/unf = 0. Sticky flags are unchanged.
- clr (ld low): count <= RST_VAL. ovf, unf, and both sticky flags are cleared.
- en, step == 0: count holds, no flags. step == 0 is a legal no-op.
- Arithmetic is performed in WIDTH+1 bits with step zero-extended. No silent modulo-2^WIDTH wrap is allowed.
- Up (mode=1):
  - Compute s = count + step.
  - If s <= MAX_VAL: count <= s.
  - Else ovf <= 1. sat=1: count <= MAX_VAL. sat=0: count <= MIN_VAL, i.e. wrap to the opposite bound, not modular remainder.
  - Exception: if count was already MAX_VAL with sat=1, count holds and ovf still pulses.
- Down (mode=0):
  - If count >= MIN_VAL + step: count <= count - step.
  - Else unf <= 1. sat=1: count <= MIN_VAL. sat=0: count <= MAX_VAL.
- ovf and unf are high for exactly one cycle per event. Back-to-back events give consecutive high cycles. Both are 0 on every cycle without an event.
- Sticky flags set in the same edge as the corresponding pulse.
- Latency: count, ovf, unf valid one cycle after the sampling edge. at_max/at_min follow count combinationally with no added latency.
- mode, sat, and step may change every cycle; each edge uses the values sampled at that edge.
- Count never leaves [MIN_VAL, MAX_VAL] after reset.

Test Plan:
All scenarios use WIDTH=8, MIN_VAL=10, MAX_VAL=20, RST_VAL=12.
1. Assert rst mid-count at 17 between clock edges -> count = 12 immediately, all flags 0. Release rst, en=1, mode=1, step=1 -> 13, 14, 15 on successive edges.
2. count=18, mode=1, step=3, sat=0 -> count = 10, ovf pulses one cycle, ovf_sticky = 1. Same with sat=1 -> count = 20, at_max = 1. Next edge with same inputs -> count holds at 20, ovf pulses again.
3. count=11, mode=0, step=2, sat=0 -> count = 20, unf pulses, unf_sticky = 1. With sat=1 -> count = 10, at_min = 1.
4. ld=1, clr=1, en=1, d_in=15 -> count = 15 (ld wins). Then ld=1, d_in=250 -> 20; d_in=3 -> 10. Sticky flags unchanged on each load.
5. With ovf_sticky=1, clr=1 and en=1 -> count = 12, both sticky flags 0, no pulse that cycle.
6. en=1, step=0 -> count holds, no flags. en=0 with step=5 -> count holds.
